imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side front end for the instruction memory write port (we0 / wr_addr0 / wr_din0).
- Accepts a byte stream on a valid/ready handshake and assembles little-endian Width-bit words.
- Writes each word to consecutive word-aligned byte addresses starting at 0.
- Holds the core in reset while loading; used for boot/program download before the single-cycle core runs.

Parameters:
- Depth, 128, number of words in the instruction memory.
- Width, 32, word width in bits; must be a multiple of 8. BPW = Width/8 bytes per word.
- AddrW, $clog2(Depth)+2, byte-address width; matches the memory's wr_addr0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a load session.
- num_words_i  in  $clog2(Depth)+1  number of words to load; sampled on start_i.
- byte_valid_i  in  1  byte_data_i is valid.
- byte_data_i  in  8  incoming program byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- we0  out  1  instruction memory write enable.
- wr_addr0  out  AddrW  byte write address, always word-aligned.
- wr_din0  out  Width  write data.
- busy_o  out  1  load session in progress.
- done_o  out  1  last session completed successfully.
- err_o  out  1  last start_i was rejected.
- cpu_hold_o  out  1  hold core in reset; equals busy_o.

Behaviour:
- Reset (reset=0, asynchronous), all outputs registered:
  - we0=0, wr_addr0=0, wr_din0=0, byte_ready_o=0, busy_o=0, done_o=0, err_o=0.
  - Internal word buffer, byte index and word counter all cleared.
  - FSM goes to IDLE.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE / DONE, start_i=1:
  - If num_words_i is 0 or greater than Depth: set err_o=1, clear done_o, stay in or return to IDLE.
  - Otherwise: latch the count, clear word_cnt, byte_idx and err_o, clear done_o, go to LOAD.
- LOAD:
  - byte_ready_o=1, busy_o=1.
  - A byte is accepted only when byte_valid_i and byte_ready_o are both 1.
  - Accepted byte k of the word (k = 0..BPW-1) goes to bits [8k+7:8k] (little-endian).
  - On acceptance of byte BPW-1, go to WRITE.
  - If no byte is valid, wait indefinitely; no timeout.
- WRITE (exactly one cycle):
  - we0=1, wr_addr0 = 4*word_cnt (in general BPW*word_cnt), wr_din0 = assembled word, byte_ready_o=0.
  - Next: word_cnt increments and byte_idx clears.
  - If the count after increment equals the latched count, go to DONE; otherwise return to LOAD.
- we0 is 0 in every state other than WRITE.
- wr_addr0 and wr_din0 hold their last values when we0=0.
- DONE:
  - done_o=1, busy_o=0, byte_ready_o=0.
  - done_o stays high until the next start_i or reset.
- Latency and throughput:
  - Write occurs the cycle after the last byte of a word is accepted.
  - Peak throughput is BPW bytes per BPW+1 cycles (4 bytes per 5 cycles at Width=32).
- Boundary conditions:
  - start_i while busy_o=1 is ignored: no restart, no error.
  - Bytes offered in IDLE, WRITE or DONE are not accepted (byte_ready_o=0) and are not consumed.
  - num_words_i == Depth fills the whole memory; last address is 4*(Depth-1); no wrap-around.
  - Reset asserted mid-session: immediate return to IDLE; the partial word is discarded; no write issued; cpu_hold_o drops.
  - byte_valid_i toggling between bytes is legal; byte order is preserved.

Test Plan:
- Reset, then start_i with num_words_i=2 and bytes 13,00,00,00,B3,02,A0,00 (hex), valid every cycle -> two one-cycle we0 pulses: addr 0 data 0x00000013, then addr 4 data 0x00A002B3; done_o=1; busy_o/cpu_hold_o high from the cycle after start through the final write.
- num_words_i=128 with the word sequence i (0..127) -> 128 writes, last at wr_addr0=508 with data 0x0000007F; a readback through rd_addr0=4*i matches every word.
- start_i with num_words_i=0, then with num_words_i=129 -> err_o=1, no we0 pulse, FSM remains IDLE; a following valid start clears err_o.
- Gapped byte_valid_i (one valid byte every 3 cycles), num_words_i=1, bytes EF,BE,AD,DE -> single write of 0xDEADBEEF at addr 0; byte_ready_o=0 during the WRITE cycle.
- Reset pulled low after 2 bytes of word 1 in a 3-word load -> outputs return to reset values immediately and no write for word 1; a restart loads correctly from addr 0.
- start_i pulsed during LOAD -> ignored; the original session completes with the original count.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Handshake: a byte transfers on a rising clk edge where byte_valid_i and byte_ready_o are both 1;
// the source holds byte_valid_i/byte_data_i stable until that edge, and ready never depends on valid.
interface imem_loader_if #(
  parameter int Width = 32,
  parameter int AddrW = 9
);
  logic             byte_valid_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o;
  logic             we0;
  logic [AddrW-1:0] wr_addr0;
  logic [Width-1:0] wr_din0;

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, we0, wr_addr0, wr_din0
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, we0, wr_addr0, wr_din0
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream and writes them to
// consecutive instruction-memory addresses while holding the core in reset.
module imem_loader #(
  parameter int Depth = 128,
  parameter int Width = 32,
  parameter int AddrW = $clog2(Depth) + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [$clog2(Depth):0]   num_words_i,
  imem_loader_if.slave             bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     cpu_hold_o,
  output logic [1:0]               state_o
);
  localparam int BPW = Width / 8;
  localparam int CW  = $clog2(Depth) + 1;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [CW-1:0]    word_cnt;
  logic [CW-1:0]    word_cnt_inc;
  logic [BIW-1:0]   byte_idx;
  logic [Width-1:0] word_buf;
  logic [Width-1:0] word_next;
  logic             accept;
  logic             last_byte;
  logic             start_ok;

  always_comb begin
    accept       = bus.byte_valid_i && bus.byte_ready_o && (state == S_LOAD);
    last_byte    = (byte_idx == BIW'(BPW - 1));
    word_cnt_inc = word_cnt + CW'(1);
    start_ok     = (num_words_i != '0) && (num_words_i <= CW'(Depth));
    word_next    = word_buf;
    word_next[int'(byte_idx) * 8 +: 8] = bus.byte_data_i;
  end

  // All outputs are registered: each branch sets the value that belongs to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      count            <= '0;
      word_cnt         <= '0;
      byte_idx         <= '0;
      word_buf         <= '0;
      bus.byte_ready_o <= 1'b0;
      bus.we0          <= 1'b0;
      bus.wr_addr0     <= '0;
      bus.wr_din0      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      bus.we0 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            done_o <= 1'b0;
            if (start_ok) begin
              count            <= num_words_i;
              word_cnt         <= '0;
              byte_idx         <= '0;
              word_buf         <= '0;
              err_o            <= 1'b0;
              busy_o           <= 1'b1;
              bus.byte_ready_o <= 1'b1;
              state            <= S_LOAD;
            end else begin
              err_o <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            word_buf <= word_next;
            if (last_byte) begin
              bus.byte_ready_o <= 1'b0;
              bus.we0          <= 1'b1;
              bus.wr_addr0     <= AddrW'(32'(word_cnt) * BPW);
              bus.wr_din0      <= word_next;
              state            <= S_WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt_inc;
          byte_idx <= '0;
          word_buf <= '0;
          if (word_cnt_inc == count) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            bus.byte_ready_o <= 1'b1;
            state            <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu_hold_o = busy_o;
  assign state_o    = state;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are issued and a
// negedge monitor pops and compares every we0 pulse.
module tb_imem_loader;
  localparam int Depth = 128;
  localparam int Width = 32;
  localparam int AddrW = 9;
  localparam int CW    = 8;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [CW-1:0] num_words_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          cpu_hold_o;
  logic [1:0]    state_o;

  imem_loader_if #(.Width(Width), .AddrW(AddrW)) bus ();

  imem_loader #(.Depth(Depth), .Width(Width), .AddrW(AddrW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .num_words_i (num_words_i),
    .bus         (bus.slave),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cpu_hold_o  (cpu_hold_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int writes;
  logic [AddrW+Width-1:0] exp_q[$];
  logic [Width-1:0]       mem [0:Depth-1];
  logic [AddrW-1:0]       last_addr;
  logic [Width-1:0]       last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.we0 === 1'b1) begin
      writes++;
      last_addr = bus.wr_addr0;
      last_data = bus.wr_din0;
      mem[bus.wr_addr0[AddrW-1:2]] = bus.wr_din0;
      check("ready_low_in_write", {63'd0, bus.byte_ready_o}, 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.wr_addr0, bus.wr_din0);
      end else begin
        logic [AddrW+Width-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr0", 64'(bus.wr_addr0), 64'(e[AddrW+Width-1:Width]));
        check("wr_din0", 64'(bus.wr_din0), 64'(e[Width-1:0]));
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [CW-1:0] n);
    start_i = 1'b1;
    num_words_i = n;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    cnt = 0;
    @(negedge clk);
    while (!bus.byte_ready_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 100) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    @(posedge clk);
    #1 bus.byte_valid_i = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [AddrW-1:0] addr, input logic [31:0] w, input int gap);
    exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (done_o !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check(name, {63'd0, done_o}, 64'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    writes = 0;
    last_addr = '0;
    last_data = '0;
    reset = 1'b0;
    start_i = 1'b0;
    num_words_i = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i = '0;
    for (int i = 0; i < Depth; i++) mem[i] = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_we0", {63'd0, bus.we0}, 64'd0);
    check("rst_addr", 64'(bus.wr_addr0), 64'd0);
    check("rst_din", 64'(bus.wr_din0), 64'd0);
    check("rst_ready", {63'd0, bus.byte_ready_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // two words, valid every cycle
    pulse_start(8'd2);
    check("t1_busy", {63'd0, busy_o}, 64'd1);
    check("t1_hold", {63'd0, cpu_hold_o}, 64'd1);
    check("t1_ready", {63'd0, bus.byte_ready_o}, 64'd1);
    check("t1_state", 64'(state_o), 64'd1);
    send_word(9'd0, 32'h0000_0013, 0);
    send_word(9'd4, 32'h00A0_02B3, 0);
    wait_done("t1_done");
    check("t1_busy_end", {63'd0, busy_o}, 64'd0);
    check("t1_hold_end", {63'd0, cpu_hold_o}, 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);
    check("t1_din_hold", 64'(bus.wr_din0), 64'h00A0_02B3);
    check("t1_writes", 64'(writes), 64'd2);

    // bytes offered in DONE are not accepted
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i = 8'hAA;
    repeat (3) @(negedge clk);
    check("done_ready", {63'd0, bus.byte_ready_o}, 64'd0);
    check("done_state", 64'(state_o), 64'd3);
    check("done_stays", {63'd0, done_o}, 64'd1);
    @(posedge clk);
    #1 bus.byte_valid_i = 1'b0;

    // rejected starts
    pulse_start(8'd0);
    check("e0_err", {63'd0, err_o}, 64'd1);
    check("e0_done", {63'd0, done_o}, 64'd0);
    check("e0_state", 64'(state_o), 64'd0);
    pulse_start(8'd129);
    check("e129_err", {63'd0, err_o}, 64'd1);
    check("e129_busy", {63'd0, busy_o}, 64'd0);
    check("e129_state", 64'(state_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("err_no_write", 64'(writes), 64'd2);

    // valid start clears err; gapped bytes
    pulse_start(8'd1);
    check("t4_err_clr", {63'd0, err_o}, 64'd0);
    send_word(9'd0, 32'hDEAD_BEEF, 2);
    wait_done("t4_done");
    check("t4_writes", 64'(writes), 64'd3);

    // reset mid-session after 2 bytes of word 1
    pulse_start(8'd3);
    send_word(9'd0, 32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    check("mid_rst_hold", {63'd0, cpu_hold_o}, 64'd0);
    check("mid_rst_ready", {63'd0, bus.byte_ready_o}, 64'd0);
    check("mid_rst_din", 64'(bus.wr_din0), 64'd0);
    check("mid_rst_state", 64'(state_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_writes", 64'(writes), 64'd4);
    check("mid_rst_q", 64'(exp_q.size()), 64'd0);
    pulse_start(8'd1);
    send_word(9'd0, 32'hCAFE_0001, 1);
    wait_done("restart_done");

    // start during LOAD is ignored
    pulse_start(8'd2);
    exp_q.push_back({9'd0, 32'h0403_0201});
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_start(8'd5);
    check("ign_busy", {63'd0, busy_o}, 64'd1);
    check("ign_err", {63'd0, err_o}, 64'd0);
    check("ign_state", 64'(state_o), 64'd1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(9'd4, 32'h0807_0605, 0);
    wait_done("ign_done");
    check("ign_writes", 64'(writes), 64'd7);

    // full memory
    pulse_start(8'd128);
    for (int i = 0; i < Depth; i++) send_word(AddrW'(4 * i), 32'(i), 0);
    wait_done("full_done");
    check("full_last_addr", 64'(last_addr), 64'd508);
    check("full_last_data", 64'(last_data), 64'h7F);
    check("full_writes", 64'(writes), 64'd135);
    for (int i = 0; i < Depth; i++) check("readback", 64'(mem[i]), 64'(i));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
